// File: rtl/fp_div_pkg.sv
// fp_div_pkg: FP constants, rounding-mode and FSM encodings shared by the FPU divider and multiplier.
package fp_div_pkg;
  localparam logic [31:0] FP_INFP  = 32'h7F80_0000;
  localparam logic [31:0] FP_INFN  = 32'hFF80_0000;
  localparam logic [31:0] FP_ZEROP = 32'h0000_0000;
  localparam logic [31:0] FP_ZERON = 32'h8000_0000;
  localparam logic [31:0] FP_NANQ  = 32'h7FC0_0000;
  localparam logic [31:0] FP_MAXP  = 32'h7F7F_FFFF;
  localparam logic [31:0] FP_MAXN  = 32'hFF7F_FFFF;
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RZ  = 3'd1;
  localparam logic [2:0] RM_RD  = 3'd2;
  localparam logic [2:0] RM_RU  = 3'd3;
  localparam logic [2:0] RM_RNA = 3'd4;
  typedef enum logic [1:0] {IDLE, ITER, ROUND} state_t;
  typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_INF, SP_DZ, SP_ZERO} spec_t;
  function automatic logic round_inc(input logic [2:0] rm, input logic s, g, t, lsb);
    return rm == RM_RNE ? g & (t | lsb) :
           rm == RM_RNA ? g :
           rm == RM_RU  ? ~s & (g | t) :
           rm == RM_RD  ? s & (g | t) : 1'b0;
  endfunction
  // Overflow saturates to infinity only when rounding moves away from zero.
  function automatic logic ov_to_inf(input logic [2:0] rm, input logic s);
    return rm == RM_RNE || rm == RM_RNA || (rm == RM_RU && !s) || (rm == RM_RD && s);
  endfunction
endpackage

// File: rtl/fp_div_mant.sv
// fp_div_mant: radix-2 restoring divider for normalized mantissas, one quotient bit per clock.
module fp_div_mant #(parameter int M = 22) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [M:0] m1,
  input  logic [M:0] m2,
  output logic       busy,
  output logic [M:0] quot,
  output logic       guard,
  output logic       sticky
);
  logic [4:0] cnt;
  logic [M+2:0] rem;
  logic [M+1:0] div, q, r_nxt;
  logic ge;
  always_comb begin
    ge = rem >= {1'b0, div};
    r_nxt = ge ? (M+2)'(rem - {1'b0, div}) : rem[M+1:0];
  end
  // Pre-shifting the dividend when Ma<Mb keeps the first quotient bit at 1; it later drops out of q.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      rem <= '0;
      div <= '0;
      q <= '0;
    end else if (start) begin
      cnt <= 5'(M + 3);
      div <= {1'b1, m2};
      rem <= m1 < m2 ? {1'b1, m1, 1'b0} : {2'b01, m1};
      q <= '0;
    end else if (busy) begin
      cnt <= cnt - 5'd1;
      rem <= {r_nxt, 1'b0};
      q <= {q[M:0], ge};
    end
  assign busy = cnt != '0;
  assign quot = q[M+1:1];
  assign guard = q[0];
  assign sticky = |rem;
endmodule

// File: rtl/fp_div.sv
// fp_div: iterative IEEE-754 single-precision divider (out = in1 / in2) with act/done handshake.
// Define FP_DIV_DZ_FLAG_EN to add the divide-by-zero output dz.
module fp_div import fp_div_pkg::*; #(
  parameter int W = 32,
  parameter int M = 22,
  parameter int E = 30,
  parameter int B = 127
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   round_m,
  output logic [W-1:0] out,
  output logic         ov,
  output logic         un,
  output logic         inv,
  output logic         inexact,
  output logic         done
`ifdef FP_DIV_DZ_FLAG_EN
  ,
  output logic         dz
`endif
);
  state_t state, nxt;
  spec_t sp, sp_in;
  logic sign, busy, guard, sticky, start, inc, c, r_ov, r_un;
  logic nan1, nan2, inf1, inf2, zero1, zero2;
  logic [2:0] rm;
  logic [E-M-1:0] e1, e2;
  logic [M:0] f1, f2, quot, fr;
  logic signed [9:0] eq, eq_in, e_r;
  logic [W-1:0] inf_s, zero_s, max_s, res;
  always_comb begin
    {e1, f1} = in1[E:0];
    {e2, f2} = in2[E:0];
    nan1 = &e1 & |f1;
    nan2 = &e2 & |f2;
    inf1 = &e1 & ~|f1;
    inf2 = &e2 & ~|f2;
    zero1 = ~|e1;
    zero2 = ~|e2;
    sp_in = (nan1 | nan2 | zero1 & zero2 | inf1 & inf2) ? SP_NAN :
            zero2 ? (inf1 ? SP_INF : SP_DZ) :
            inf1 ? SP_INF :
            (zero1 | inf2) ? SP_ZERO : SP_NONE;
    eq_in = 10'(e1) - 10'(e2) + 10'(B) - 10'(f1 < f2);
    start = state == IDLE && act && sp_in == SP_NONE;
    // Special cases leave the datapath idle, so ITER falls straight through to ROUND.
    nxt = state == IDLE ? (act ? ITER : IDLE) :
          state == ITER ? (busy ? ITER : ROUND) : IDLE;
  end
  fp_div_mant #(.M(M)) u_mant (
    .clk(clk),
    .rst(rst),
    .start(start),
    .m1(f1),
    .m2(f2),
    .busy(busy),
    .quot(quot),
    .guard(guard),
    .sticky(sticky)
  );
  always_comb begin
    inc = round_inc(rm, sign, guard, sticky, quot[0]);
    {c, fr} = {1'b0, quot} + (M+2)'(inc);
    e_r = eq + 10'(c);
    r_ov = e_r > 10'sd254;
    r_un = e_r < 10'sd1;
    inf_s = sign ? FP_INFN : FP_INFP;
    zero_s = sign ? FP_ZERON : FP_ZEROP;
    max_s = sign ? FP_MAXN : FP_MAXP;
    res = sp == SP_NAN ? FP_NANQ :
          (sp == SP_INF || sp == SP_DZ) ? inf_s :
          sp == SP_ZERO ? zero_s :
          r_ov ? (ov_to_inf(rm, sign) ? inf_s : max_s) :
          r_un ? zero_s : {sign, e_r[E-M-1:0], fr};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sign <= 1'b0;
      rm <= '0;
      eq <= '0;
      sp <= SP_NONE;
      out <= '0;
      ov <= 1'b0;
      un <= 1'b0;
      inv <= 1'b0;
      inexact <= 1'b0;
      done <= 1'b0;
`ifdef FP_DIV_DZ_FLAG_EN
      dz <= 1'b0;
`endif
    end else begin
      state <= nxt;
      done <= state == ROUND;
      if (state == IDLE && act) begin
        sign <= in1[W-1] ^ in2[W-1];
        rm <= round_m;
        eq <= eq_in;
        sp <= sp_in;
      end
      if (state == ROUND) begin
        out <= res;
        inv <= sp == SP_NAN;
        ov <= sp == SP_NONE && r_ov;
        un <= sp == SP_NONE && r_un;
        inexact <= sp == SP_NONE && (guard | sticky | r_ov | r_un);
`ifdef FP_DIV_DZ_FLAG_EN
        dz <= sp == SP_DZ;
`endif
      end
    end
endmodule
